// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator call scheduler, display and motor driver.
package elevator_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_t;

    localparam int MAX_FLOORS = 8;

    function automatic int floor_w(input int floors);
        return (floors <= 2) ? 1 : $clog2(floors);
    endfunction

    typedef logic [floor_w(MAX_FLOORS)-1:0] floor_t;

endpackage

// File: rtl/door_dwell_timer.sv
// Loadable down-counter timing how long the door stays open.
module door_dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN-policy car scheduler: latches floor calls, commands motor and door.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS       = 4,
    parameter int FW           = 2,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] call_pulse,
    input  logic [FW-1:0]     cur_floor,
    input  logic              at_floor,
    output logic              move_up,
    output logic              move_down,
    output logic              door_open,
    output logic              dir_up,
    output logic [FLOORS-1:0] pending,
    output logic [ST_W-1:0]   state
);

    state_t            st, st_n;
    logic              dir_q, dir_n;
    logic [FLOORS-1:0] pend_q, pend_n;
    logic [FLOORS-1:0] cur_bit;
    logic              here, above, below;
    logic              enter_door, reopen, load, expired;

    // Out-of-range floor positions see no calls at all.
    always_comb begin
        here    = 1'b0;
        above   = 1'b0;
        below   = 1'b0;
        cur_bit = '0;
        if (int'(cur_floor) < FLOORS) begin
            for (int i = 0; i < FLOORS; i++) begin
                if (int'(cur_floor) == i) begin
                    cur_bit[i] = 1'b1;
                    here       = pend_q[i];
                end else if (int'(cur_floor) < i) begin
                    above = above | pend_q[i];
                end else begin
                    below = below | pend_q[i];
                end
            end
        end
    end

    assign reopen = (st == ST_DOOR) && (|(call_pulse & cur_bit));

    always_comb begin
        st_n  = st;
        dir_n = dir_q;
        unique case (st)
            ST_IDLE: begin
                if (here && at_floor) begin
                    st_n = ST_DOOR;
                end else if (dir_q && above) begin
                    st_n = ST_UP;
                end else if (!dir_q && below) begin
                    st_n = ST_DOWN;
                end else if (above) begin
                    st_n  = ST_UP;
                    dir_n = 1'b1;
                end else if (below) begin
                    st_n  = ST_DOWN;
                    dir_n = 1'b0;
                end
            end
            ST_UP: begin
                if (at_floor && here) begin
                    st_n = ST_DOOR;
                end else if (at_floor && !above) begin
                    st_n = ST_IDLE;
                end
            end
            ST_DOWN: begin
                if (at_floor && here) begin
                    st_n = ST_DOOR;
                end else if (at_floor && !below) begin
                    st_n = ST_IDLE;
                end
            end
            ST_DOOR: begin
                if (!reopen && expired) begin
                    st_n = ST_IDLE;
                end
            end
            default: st_n = ST_IDLE;
        endcase
    end

    assign enter_door = (st != ST_DOOR) && (st_n == ST_DOOR);
    assign load       = enter_door || reopen;

    // A call for the floor being served never re-latches; clearing wins.
    always_comb begin
        pend_n = pend_q | (call_pulse & ~((st == ST_DOOR) ? cur_bit : '0));
        if (enter_door) begin
            pend_n = pend_n & ~cur_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= ST_IDLE;
            dir_q  <= 1'b1;
            pend_q <= '0;
        end else begin
            st     <= st_n;
            dir_q  <= dir_n;
            pend_q <= pend_n;
        end
    end

    door_dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .expired(expired)
    );

    assign move_up   = (st == ST_UP);
    assign move_down = (st == ST_DOWN);
    assign door_open = (st == ST_DOOR);
    assign dir_up    = dir_q;
    assign pending   = pend_q;
    assign state     = st;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed scoreboard bench for elevator_call_scheduler (4 floors, dwell 4).
module tb_elevator_call_scheduler;

    localparam int FLOORS = 4;
    localparam int FW     = 2;
    localparam int DWELL  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [FLOORS-1:0] call_pulse = '0;
    logic [FW-1:0]     cur_floor = '0;
    logic              at_floor = 1'b1;
    logic              move_up, move_down, door_open, dir_up;
    logic [FLOORS-1:0] pending;
    logic [1:0]        state;

    elevator_call_scheduler #(
        .FLOORS      (FLOORS),
        .FW          (FW),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call_pulse(call_pulse),
        .cur_floor (cur_floor),
        .at_floor  (at_floor),
        .move_up   (move_up),
        .move_down (move_down),
        .door_open (door_open),
        .dir_up    (dir_up),
        .pending   (pending),
        .state     (state)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    string      tag_q[$];
    logic [7:0] exp_q[$];

    // Global motion invariants watched every cycle
    logic prev_door = 1'b0;
    int   adj_viol  = 0;
    int   both_viol = 0;
    int   motor_cnt = 0;

    always @(negedge clk) begin
        if (move_up && move_down) both_viol++;
        if (prev_door && (move_up || move_down)) adj_viol++;
        if (move_up || move_down) motor_cnt++;
        prev_door = door_open;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [7:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        call_pulse = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (door_open === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int base;

        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;

        // Reset state
        cur_floor = 2'd0;
        at_floor  = 1'b1;
        do_reset();
        push("rst_state", 8'd0);
        push("rst_dir", 8'd1);
        push("rst_outs", 8'd0);
        push("rst_pend", 8'd0);
        pop_chk(8'(state));
        pop_chk(8'(dir_up));
        pop_chk({5'b0, door_open, move_down, move_up});
        pop_chk(8'(pending));

        // 1: call above an idle car
        call_pulse = 4'b0100;
        push("t1_pend", 8'h4);
        tick();
        call_pulse = '0;
        pop_chk(8'(pending));
        push("t1_up", 8'd1);
        tick();
        pop_chk(8'(move_up));
        cur_floor = 2'd2;
        push("t1_door", 8'd1);
        push("t1_pclr", 8'd0);
        tick();
        pop_chk(8'(door_open));
        pop_chk(8'(pending));
        count_door(n);
        push("t1_dwell", 8'(DWELL));
        pop_chk(8'(n));
        push("t1_idle", 8'd0);
        pop_chk(8'(state));

        // 2: SCAN ordering
        cur_floor = 2'd1;
        do_reset();
        call_pulse = 4'b1001;
        push("t2_pend", 8'h9);
        tick();
        call_pulse = '0;
        pop_chk(8'(pending));
        push("t2_up", 8'd1);
        tick();
        pop_chk(8'(move_up));
        cur_floor = 2'd2;
        push("t2_hold_up", 8'd1);
        tick();
        pop_chk(8'(move_up));
        cur_floor = 2'd3;
        push("t2_door3", 8'd1);
        push("t2_dir3", 8'd1);
        push("t2_pend3", 8'h1);
        tick();
        pop_chk(8'(door_open));
        pop_chk(8'(dir_up));
        pop_chk(8'(pending));
        count_door(n);
        push("t2_dwell3", 8'(DWELL));
        pop_chk(8'(n));
        push("t2_idle", 8'd0);
        pop_chk(8'(state));
        push("t2_down", 8'd1);
        push("t2_dir0", 8'd0);
        tick();
        pop_chk(8'(move_down));
        pop_chk(8'(dir_up));
        cur_floor = 2'd2;
        push("t2_hold_dn", 8'd1);
        tick();
        pop_chk(8'(move_down));
        cur_floor = 2'd0;
        push("t2_door0", 8'd1);
        push("t2_pend0", 8'd0);
        tick();
        pop_chk(8'(door_open));
        pop_chk(8'(pending));
        count_door(n);
        push("t2_dwell0", 8'(DWELL));
        pop_chk(8'(n));

        // 3: door reopen on the third dwell cycle
        cur_floor = 2'd2;
        do_reset();
        call_pulse = 4'b0100;
        tick();
        call_pulse = '0;
        push("t3_door", 8'd1);
        tick();
        pop_chk(8'(door_open));
        tick();
        tick();
        call_pulse = 4'b0100;
        push("t3_pend", 8'd0);
        push("t3_dwell", 8'(3 + DWELL));
        tick();
        call_pulse = '0;
        pop_chk(8'(pending));
        count_door(n);
        pop_chk(8'(3 + n));

        // 4: set and clear of the same bit in one cycle
        cur_floor = 2'd1;
        do_reset();
        call_pulse = 4'b0010;
        tick();
        call_pulse = 4'b1010;
        push("t4_door", 8'd1);
        push("t4_pend", 8'h8);
        tick();
        call_pulse = '0;
        pop_chk(8'(door_open));
        pop_chk(8'(pending));

        // 5: reset while moving down
        cur_floor = 2'd3;
        do_reset();
        call_pulse = 4'b0011;
        tick();
        call_pulse = '0;
        push("t5_down", 8'd1);
        tick();
        pop_chk(8'(move_down));
        reset = 1'b1;
        push("t5_pend", 8'd0);
        push("t5_outs", 8'd0);
        push("t5_dir", 8'd1);
        push("t5_state", 8'd0);
        tick();
        reset = 1'b0;
        pop_chk(8'(pending));
        pop_chk({5'b0, door_open, move_down, move_up});
        pop_chk(8'(dir_up));
        pop_chk(8'(state));

        // 6: call at the current floor while idle
        cur_floor = 2'd3;
        do_reset();
        base = motor_cnt;
        call_pulse = 4'b1000;
        tick();
        call_pulse = '0;
        push("t6_door", 8'd1);
        tick();
        pop_chk(8'(door_open));
        count_door(n);
        push("t6_dwell", 8'(DWELL));
        pop_chk(8'(n));
        tick();
        tick();
        push("t6_motor", 8'd0);
        pop_chk(8'(motor_cnt - base));

        push("adjacent_motor", 8'd0);
        pop_chk(8'(adj_viol));
        push("both_motor", 8'd0);
        pop_chk(8'(both_viol));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
